// File: rtl/irq_or_collector.sv
// Collects N asynchronous interrupt lines into sticky pending bits, then masks and OR-reduces
// them into one registered IRQ with a registered lowest-index-first IRQ_ID.
module irq_or_collector #(
  parameter int unsigned N_SRC       = 8,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned ID_W       = $clog2(N_SRC)
) (
  input  logic             CLK,
  input  logic             R,
  input  logic [N_SRC-1:0] SRC,
  input  logic [N_SRC-1:0] EDGE_SEL,
  input  logic [N_SRC-1:0] MASK,
  input  logic [N_SRC-1:0] CLR,
  input  logic             IRQ_ACK,
  output logic [N_SRC-1:0] PEND,
  output logic             IRQ,
  output logic [ID_W-1:0]  IRQ_ID
);

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] prev_q;
  logic [N_SRC-1:0] pend_q, pend_d;
  logic             irq_q, irq_d;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;

  logic [N_SRC-1:0] sync_s;
  logic [N_SRC-1:0] set_vec;
  logic [N_SRC-1:0] clr_vec;
  logic [N_SRC-1:0] active;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      for (int k = 0; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= SRC;
      for (int k = 1; k < int'(SYNC_STAGES); k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // prev_q clears on reset, so a line already high at release is seen as a rising edge.
  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      prev_q <= '0;
    end else begin
      prev_q <= sync_s;
    end
  end

  // An ack retires only the index the core saw, and only while IRQ is actually raised.
  always_comb begin
    set_vec = sync_s & ~prev_q;
    clr_vec = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      clr_vec[i] = CLR[i] | (IRQ_ACK & irq_q & (irq_id_q == ID_W'(i)));
    end
  end

  always_comb begin
    pend_d = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (EDGE_SEL[i]) begin
        pend_d[i] = set_vec[i] | (pend_q[i] & ~clr_vec[i]);
      end else begin
        pend_d[i] = sync_s[i];
      end
    end
  end

  always_comb begin
    active   = pend_q & MASK;
    irq_d    = |active;
    irq_id_d = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (active[i]) begin
        irq_id_d = ID_W'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge R) begin
    if (!R) begin
      pend_q   <= '0;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      pend_q   <= pend_d;
      irq_q    <= irq_d;
      irq_id_q <= irq_id_d;
    end
  end

  assign PEND   = pend_q;
  assign IRQ    = irq_q;
  assign IRQ_ID = irq_id_q;

endmodule

// File: tb/tb_irq_or_collector.sv
// Scoreboard bench for irq_or_collector: expectations are queued with a due cycle when stimulus
// is driven and compared on the falling edge of that cycle.
module tb_irq_or_collector;

  logic       CLK;
  logic       R;
  logic [7:0] SRC;
  logic [7:0] EDGE_SEL;
  logic [7:0] MASK;
  logic [7:0] CLR;
  logic       IRQ_ACK;
  logic [7:0] PEND;
  logic       IRQ;
  logic [2:0] IRQ_ID;

  irq_or_collector #(
    .N_SRC      (8),
    .SYNC_STAGES(2)
  ) dut (
    .CLK     (CLK),
    .R       (R),
    .SRC     (SRC),
    .EDGE_SEL(EDGE_SEL),
    .MASK    (MASK),
    .CLR     (CLR),
    .IRQ_ACK (IRQ_ACK),
    .PEND    (PEND),
    .IRQ     (IRQ),
    .IRQ_ID  (IRQ_ID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    int         due;
    string      tag;
    int         sel;
    logic [7:0] val;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %h, want %h", tag, cyc, got, want);
    end
  endtask

  // Pops every expectation that falls due on this cycle.
  always @(negedge CLK) begin
    for (int i = int'(sb.size()) - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        case (sb[i].sel)
          0:       chk({sb[i].tag, ".pend"}, PEND, sb[i].val);
          1:       chk({sb[i].tag, ".irq"}, {7'd0, IRQ}, sb[i].val);
          default: chk({sb[i].tag, ".id"}, {5'd0, IRQ_ID}, sb[i].val);
        endcase
        sb.delete(i);
      end
    end
  end

  task automatic exp_all(input int dly, input string tag, input logic [7:0] pend,
                         input logic irq, input logic [2:0] id);
    exp_t e;
    e.due = cyc + dly;
    e.tag = tag;
    e.sel = 0; e.val = pend;          sb.push_back(e);
    e.sel = 1; e.val = {7'd0, irq};   sb.push_back(e);
    e.sel = 2; e.val = {5'd0, id};    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    R = 1'b0; SRC = '0; EDGE_SEL = '1; MASK = '1; CLR = '0; IRQ_ACK = 1'b0;
    tick(3);
    R = 1'b1;

    // Reset release with quiet sources.
    for (int d = 1; d <= 10; d++) exp_all(d, "t1", 8'h00, 1'b0, 3'd0);
    tick(11);

    // Single edge on bit 3, then ack.
    SRC = 8'h08;
    exp_all(2, "t2.pre", 8'h00, 1'b0, 3'd0);
    exp_all(3, "t2.pend", 8'h08, 1'b0, 3'd0);
    exp_all(4, "t2.irq", 8'h08, 1'b1, 3'd3);
    tick(1); SRC = 8'h00;
    tick(3);
    IRQ_ACK = 1'b1;
    exp_all(1, "t2.ack1", 8'h00, 1'b1, 3'd3);
    exp_all(2, "t2.ack2", 8'h00, 1'b0, 3'd0);
    tick(1); IRQ_ACK = 1'b0;
    tick(3);

    // Two simultaneous edges retired lowest index first.
    SRC = 8'h22;
    exp_all(3, "t3.pend", 8'h22, 1'b0, 3'd0);
    exp_all(4, "t3.irq", 8'h22, 1'b1, 3'd1);
    tick(1); SRC = 8'h00;
    tick(3);
    IRQ_ACK = 1'b1;
    exp_all(1, "t3.ack1a", 8'h20, 1'b1, 3'd1);
    exp_all(2, "t3.ack1b", 8'h20, 1'b1, 3'd5);
    tick(1); IRQ_ACK = 1'b0;
    tick(1); IRQ_ACK = 1'b1;
    exp_all(1, "t3.ack2a", 8'h00, 1'b1, 3'd5);
    exp_all(2, "t3.ack2b", 8'h00, 1'b0, 3'd0);
    tick(1); IRQ_ACK = 1'b0;
    tick(3);

    // Masked source still pends; unmasking raises IRQ one edge later; CLR clears.
    MASK = 8'h00; SRC = 8'h04;
    exp_all(3, "t4.pend", 8'h04, 1'b0, 3'd0);
    exp_all(4, "t4.masked", 8'h04, 1'b0, 3'd0);
    tick(1); SRC = 8'h00;
    tick(4);
    MASK = 8'h04;
    exp_all(1, "t4.unmask", 8'h04, 1'b1, 3'd2);
    tick(1); CLR = 8'h04;
    exp_all(1, "t4.clr1", 8'h00, 1'b1, 3'd2);
    exp_all(2, "t4.clr2", 8'h00, 1'b0, 3'd0);
    tick(1); CLR = 8'h00; MASK = '1;
    tick(3);

    // Level mode on bit 0: ack and CLR do not clear, release follows the source.
    EDGE_SEL = 8'hFE; SRC = 8'h01;
    exp_all(3, "t5.pend", 8'h01, 1'b0, 3'd0);
    exp_all(4, "t5.irq", 8'h01, 1'b1, 3'd0);
    tick(4);
    IRQ_ACK = 1'b1; CLR = 8'h01;
    exp_all(1, "t5.ack1", 8'h01, 1'b1, 3'd0);
    exp_all(2, "t5.ack2", 8'h01, 1'b1, 3'd0);
    tick(1); IRQ_ACK = 1'b0; CLR = 8'h00;
    tick(2);
    SRC = 8'h00;
    exp_all(2, "t5.hold", 8'h01, 1'b1, 3'd0);
    exp_all(3, "t5.fall", 8'h00, 1'b1, 3'd0);
    exp_all(4, "t5.irq0", 8'h00, 1'b0, 3'd0);
    tick(5);
    EDGE_SEL = '1;
    tick(3);

    // CLR coincident with a fresh synchronised rise on bit 4: the set wins.
    SRC = 8'h10;
    exp_all(4, "t6.first", 8'h10, 1'b1, 3'd4);
    tick(1); SRC = 8'h00;
    tick(3);
    SRC = 8'h10;
    tick(1); SRC = 8'h00;
    tick(1); CLR = 8'h10;
    exp_all(1, "t6.coinc", 8'h10, 1'b1, 3'd4);
    tick(1); CLR = 8'h00;
    exp_all(1, "t6.after", 8'h10, 1'b1, 3'd4);
    tick(1); CLR = 8'h10;
    exp_all(1, "t6.clr1", 8'h00, 1'b1, 3'd4);
    exp_all(2, "t6.clr2", 8'h00, 1'b0, 3'd0);
    tick(1); CLR = 8'h00;
    tick(3);

    // Asynchronous reset mid-pending; a line held high through reset counts as an edge.
    SRC = 8'h80;
    exp_all(4, "t7.pre", 8'h80, 1'b1, 3'd7);
    tick(5);
    #3 R = 1'b0;
    #1;
    chk("t7.rst.pend", PEND, 8'h00);
    chk("t7.rst.irq", {7'd0, IRQ}, 8'h00);
    chk("t7.rst.id", {5'd0, IRQ_ID}, 8'h00);
    tick(2);
    R = 1'b1;
    exp_all(2, "t7.rel", 8'h00, 1'b0, 3'd0);
    exp_all(3, "t7.pend", 8'h80, 1'b0, 3'd0);
    exp_all(4, "t7.irq", 8'h80, 1'b1, 3'd7);
    tick(1); SRC = 8'h00;
    tick(5);

    for (int w = 0; w < 20 && sb.size() != 0; w++) tick(1);
    if (sb.size() != 0) chk("sb_drain", 8'(sb.size()), 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
